// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection phase controller with a pedestrian walk phase.
// One down-counting phase timer, latched side/walk requests, and a Moore FSM with registered lamps.
module traffic_phase_ctrl #(
  parameter int TW         = 8,
  parameter int T_MAIN_MIN = 8,
  parameter int T_YEL      = 3,
  parameter int T_RED      = 1,
  parameter int T_SIDE     = 5,
  parameter int T_EXT      = 3,
  parameter int T_WALK     = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_sync,
  input  logic       walk_sync,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk_light,
  output logic       walk_pending,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    RED_A  = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    RED_B  = 3'd5,
    WALK   = 3'd6
  } phase_t;

  localparam logic [TW-1:0] LD_MAIN = TW'(T_MAIN_MIN - 1);
  localparam logic [TW-1:0] LD_YEL  = TW'(T_YEL - 1);
  localparam logic [TW-1:0] LD_RED  = TW'(T_RED - 1);
  localparam logic [TW-1:0] LD_SIDE = TW'(T_SIDE - 1);
  localparam logic [TW-1:0] LD_EXT  = TW'(T_EXT - 1);
  localparam logic [TW-1:0] LD_WALK = TW'(T_WALK - 1);

  phase_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic          ext, ext_n;
  logic          wprev;
  logic          side_req;
  logic          expired;
  logic          rise;

  assign expired = (timer == '0);
  assign rise    = walk_sync & ~wprev;
  assign phase   = state;

  always_comb begin
    state_n = state;
    timer_n = timer - 1'b1;
    ext_n   = ext;
    case (state)
      MAIN_G: if (expired) begin
        timer_n = '0;
        if (side_req | walk_pending) begin
          state_n = MAIN_Y;
          timer_n = LD_YEL;
        end
      end
      MAIN_Y: if (expired) begin
        state_n = RED_A;
        timer_n = LD_RED;
      end
      RED_A: if (expired) begin
        if (side_req) begin
          state_n = SIDE_G;
          timer_n = LD_SIDE;
          ext_n   = 1'b0;
        end else begin
          state_n = WALK;
          timer_n = LD_WALK;
        end
      end
      // One extension per visit: the flag is cleared only on entry from RED_A.
      SIDE_G: if (expired) begin
        if (sensor_sync && !ext) begin
          timer_n = LD_EXT;
          ext_n   = 1'b1;
        end else begin
          state_n = SIDE_Y;
          timer_n = LD_YEL;
        end
      end
      SIDE_Y: if (expired) begin
        state_n = RED_B;
        timer_n = LD_RED;
      end
      RED_B: if (expired) begin
        if (walk_pending) begin
          state_n = WALK;
          timer_n = LD_WALK;
        end else begin
          state_n = MAIN_G;
          timer_n = LD_MAIN;
        end
      end
      WALK: if (expired) begin
        state_n = MAIN_G;
        timer_n = LD_MAIN;
      end
      default: begin
        state_n = MAIN_G;
        timer_n = LD_MAIN;
      end
    endcase
  end

  // Lamps are registered from the next state so they change on the same edge as phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= MAIN_G;
      timer        <= LD_MAIN;
      ext          <= 1'b0;
      wprev        <= 1'b0;
      walk_pending <= 1'b0;
      side_req     <= 1'b0;
      main_light   <= 3'b001;
      side_light   <= 3'b100;
      walk_light   <= 1'b0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      ext          <= ext_n;
      wprev        <= walk_sync;
      walk_pending <= (state == WALK) ? 1'b0 : (walk_pending | rise);
      side_req     <= (state == SIDE_G) ? 1'b0 : (side_req | sensor_sync);
      main_light   <= (state_n == MAIN_G) ? 3'b001 : (state_n == MAIN_Y) ? 3'b010 : 3'b100;
      side_light   <= (state_n == SIDE_G) ? 3'b001 : (state_n == SIDE_Y) ? 3'b010 : 3'b100;
      walk_light   <= (state_n == WALK);
    end
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: directed scenarios plus random traffic,
// compared each cycle against an age/limit phase model.
module tb_traffic_phase_ctrl;

  localparam int P_MAIN = 8, P_YEL = 3, P_RED = 1, P_SIDE = 5, P_EXT = 3, P_WALK = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sensor_sync = 1'b0;
  logic       walk_sync = 1'b0;
  logic [2:0] main_light, side_light, phase;
  logic       walk_light, walk_pending;
  logic [10:0] got;

  int checks = 0;
  int errors = 0;

  // Model state: phase, cycles spent in this visit, visit length, request bits.
  int m_ph, m_age, m_lim;
  bit m_ext, m_wp, m_sr, m_wprev;

  traffic_phase_ctrl #(
    .TW(8), .T_MAIN_MIN(P_MAIN), .T_YEL(P_YEL), .T_RED(P_RED),
    .T_SIDE(P_SIDE), .T_EXT(P_EXT), .T_WALK(P_WALK)
  ) dut (
    .clk(clk), .reset(reset), .sensor_sync(sensor_sync), .walk_sync(walk_sync),
    .main_light(main_light), .side_light(side_light), .walk_light(walk_light),
    .walk_pending(walk_pending), .phase(phase)
  );

  always #5 clk = ~clk;

  function automatic int dur(input int p);
    case (p)
      0: return P_MAIN;
      1: return P_YEL;
      2: return P_RED;
      3: return P_SIDE;
      4: return P_YEL;
      5: return P_RED;
      default: return P_WALK;
    endcase
  endfunction

  task automatic m_reset();
    m_ph = 0; m_age = 0; m_lim = P_MAIN;
    m_ext = 0; m_wp = 0; m_sr = 0; m_wprev = 0;
  endtask

  task automatic m_step(input bit s, input bit w);
    bit done, wp_n, sr_n;
    int nph;
    done = (m_age >= m_lim - 1);
    wp_n = (m_ph == 6) ? 1'b0 : (m_wp | (w & ~m_wprev));
    sr_n = (m_ph == 3) ? 1'b0 : (m_sr | s);
    nph = m_ph;
    if (done) begin
      case (m_ph)
        0: if (m_sr || m_wp) nph = 1;
        1: nph = 2;
        2: nph = m_sr ? 3 : 6;
        3: if (s && !m_ext) begin m_lim += P_EXT; m_ext = 1; end else nph = 4;
        4: nph = 5;
        5: nph = m_wp ? 6 : 0;
        default: nph = 0;
      endcase
    end
    if (nph != m_ph) begin
      m_ph = nph; m_age = 0; m_lim = dur(nph);
      if (nph == 3) m_ext = 0;
    end else begin
      m_age++;
    end
    m_wp = wp_n; m_sr = sr_n; m_wprev = w;
  endtask

  function automatic logic [10:0] m_vec();
    logic [2:0] ml, sl;
    ml = (m_ph == 0) ? 3'b001 : (m_ph == 1) ? 3'b010 : 3'b100;
    sl = (m_ph == 3) ? 3'b001 : (m_ph == 4) ? 3'b010 : 3'b100;
    return {3'(m_ph), ml, sl, (m_ph == 6), m_wp};
  endfunction

  // One clock: drive inputs, advance DUT and model on the edge, sample 1 time unit later.
  task automatic tick(input bit s, input bit w, input bit r);
    sensor_sync = s; walk_sync = w; reset = r;
    @(posedge clk); #1;
    if (r) m_reset(); else m_step(s, w);
    got = {phase, main_light, side_light, walk_light, walk_pending};
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick(0, 0, 1);
    tick(0, 0, 1);
    checks++;
    if (got !== 11'b000_001_100_0_0) begin
      errors++; $display("FAIL reset_state got %b exp %b", got, 11'b000_001_100_0_0);
    end
    for (int i = 0; i < 100; i++) begin
      tick(0, 0, 0);
      checks++;
      if (got !== 11'b000_001_100_0_0 || got !== m_vec()) begin
        errors++; $display("FAIL idle cyc %0d got %b exp %b", i, got, m_vec());
      end
    end
  endtask

  task automatic test_sensor_dwell();
    int log_ph[$];
    int run_ph[$], run_len[$];
    int exp_ph[6]  = '{0, 1, 2, 3, 4, 5};
    int exp_len[6] = '{P_MAIN, P_YEL, P_RED, P_SIDE + P_EXT, P_YEL, P_RED};
    tick(1, 0, 1);
    log_ph.push_back(int'(phase));
    for (int i = 0; i < 30; i++) begin
      tick(1, 0, 0);
      log_ph.push_back(int'(phase));
      checks++;
      if (got !== m_vec()) begin
        errors++; $display("FAIL sensor_model cyc %0d got %b exp %b", i, got, m_vec());
      end
    end
    foreach (log_ph[i]) begin
      if (i == 0 || log_ph[i] != log_ph[i-1]) begin
        run_ph.push_back(log_ph[i]); run_len.push_back(1);
      end else run_len[run_len.size()-1]++;
    end
    checks++;
    if (run_ph.size() < 7) begin
      errors++; $display("FAIL sensor_runs got %0d exp >=7", run_ph.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (run_ph[k] != exp_ph[k] || run_len[k] != exp_len[k]) begin
          errors++;
          $display("FAIL sensor_dwell run %0d got ph %0d len %0d exp ph %0d len %0d",
                   k, run_ph[k], run_len[k], exp_ph[k], exp_len[k]);
        end
      end
      checks++;
      if (run_ph[6] != 0) begin
        errors++; $display("FAIL sensor_return got %0d exp 0", run_ph[6]);
      end
    end
  endtask

  task automatic test_walk_pulse();
    int walk_cycles = 0;
    int walk_seen = 0;
    tick(0, 0, 1);
    for (int c = 1; c <= 19; c++) tick(0, 0, 0);
    tick(0, 1, 0);
    checks++;
    if (walk_pending !== 1'b1) begin
      errors++; $display("FAIL walk_latch got %b exp 1", walk_pending);
    end
    for (int i = 0; i < 25; i++) begin
      tick(0, 0, 0);
      checks++;
      if (got !== m_vec()) begin
        errors++; $display("FAIL walk_model cyc %0d got %b exp %b", i, got, m_vec());
      end
      if (walk_light) begin
        walk_seen++;
        walk_cycles++;
        if (walk_seen == 2) begin
          checks++;
          if (walk_pending !== 1'b0) begin
            errors++; $display("FAIL walk_clear got %b exp 0", walk_pending);
          end
        end
      end
    end
    checks++;
    if (walk_cycles != P_WALK) begin
      errors++; $display("FAIL walk_len got %0d exp %0d", walk_cycles, P_WALK);
    end
  endtask

  task automatic test_side_then_walk();
    int run_ph[$];
    int side_len = 0;
    int exp_ph[8] = '{0, 1, 2, 3, 4, 5, 6, 0};
    tick(0, 0, 1);
    run_ph.push_back(int'(phase));
    for (int c = 1; c <= 40; c++) begin
      tick(c == 2, c == 3, 0);
      checks++;
      if (got !== m_vec()) begin
        errors++; $display("FAIL sw_model cyc %0d got %b exp %b", c, got, m_vec());
      end
      if (int'(phase) != run_ph[run_ph.size()-1]) run_ph.push_back(int'(phase));
      if (phase == 3'd3) side_len++;
    end
    checks++;
    if (side_len != P_SIDE) begin
      errors++; $display("FAIL sw_side_len got %0d exp %0d", side_len, P_SIDE);
    end
    checks++;
    if (run_ph.size() < 8) begin
      errors++; $display("FAIL sw_order got %0d phases exp 8", run_ph.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (run_ph[k] != exp_ph[k]) begin
          errors++; $display("FAIL sw_order idx %0d got %0d exp %0d", k, run_ph[k], exp_ph[k]);
        end
      end
    end
  endtask

  task automatic test_held_button();
    int entries = 0;
    logic [2:0] prev;
    tick(0, 0, 1);
    prev = phase;
    for (int c = 0; c < 80; c++) begin
      tick(0, c < 40, 0);
      checks++;
      if (got !== m_vec()) begin
        errors++; $display("FAIL held_model cyc %0d got %b exp %b", c, got, m_vec());
      end
      if (phase == 3'd6 && prev != 3'd6) entries++;
      prev = phase;
    end
    checks++;
    if (entries != 1) begin
      errors++; $display("FAIL held_walks got %0d exp 1", entries);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    tick(0, 0, 1);
    for (int c = 0; c < 60 && !found; c++) begin
      tick(1, 1, 0);
      if (m_ph == 3 && m_ext) found = 1;
    end
    checks++;
    if (!found || phase !== 3'd3) begin
      errors++; $display("FAIL mid_reach got phase %0d exp 3", phase);
    end
    tick(1, 0, 1);
    checks++;
    if (got !== 11'b000_001_100_0_0) begin
      errors++; $display("FAIL mid_reset got %b exp %b", got, 11'b000_001_100_0_0);
    end
    for (int c = 0; c < 12; c++) begin
      tick(0, 0, 0);
      checks++;
      if (phase !== 3'd0 || got !== m_vec()) begin
        errors++; $display("FAIL mid_cleared cyc %0d got %b exp %b", c, got, m_vec());
      end
    end
    // Fresh minimum: a request right after reset must wait the full main-green time.
    tick(0, 0, 1);
    for (int c = 1; c <= P_MAIN; c++) begin
      tick(c == 1, 0, 0);
      checks++;
      if (got !== m_vec() || phase !== ((c < P_MAIN) ? 3'd0 : 3'd1)) begin
        errors++; $display("FAIL mid_min cyc %0d got %b exp %b", c, got, m_vec());
      end
    end
  endtask

  task automatic test_random();
    tick(0, 0, 1);
    for (int c = 0; c < 1500; c++) begin
      tick($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0);
      checks++;
      if (got !== m_vec()) begin
        errors++; $display("FAIL rand cyc %0d got %b exp %b", c, got, m_vec());
      end
    end
  endtask

  initial begin
    m_reset();
    @(negedge clk);
    test_reset();
    test_sensor_dwell();
    test_walk_pulse();
    test_side_then_walk();
    test_held_button();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
